// File: rtl/data_path_pipe.sv
`default_nettype none
// ============================================================================
// Module  : data_path_pipe
// Brief   : Two-stage datapath with register file, ALU, writeback register,
//           a valid/ready data-memory port and a saturating stall counter.
//           Optional writeback forwarding: define DATA_PATH_FWD_EN.
// Revision: 1.0 - initial release
// ============================================================================
module data_path_pipe #(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 16,
  parameter  int ADDR_W  = 8,
  localparam int ID_W    = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ID_W-1:0]   dst_id,
  input  logic [ID_W-1:0]   src1_id,
  input  logic [ID_W-1:0]   src2_id,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        alu_cmd,
  input  logic [1:0]        dst_sel,
  input  logic              reg_wr_en,
  input  logic [1:0]        mem_op,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_data,
  input  logic [ID_W-1:0]   dbg_rd_id,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_REQ = 2'd1,
    S_RSP = 2'd2
  } state_t;

  localparam logic [15:0] c_stall_max = 16'hFFFF;

  state_t              r_state;
  logic [DATA_W-1:0]   r_rf [REG_CNT];
  logic                r_w_valid;
  logic                r_w_we;
  logic [ID_W-1:0]     r_w_dst;
  logic [DATA_W-1:0]   r_w_data;
  logic                r_req_valid;
  logic                r_req_we;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [DATA_W-1:0]   r_req_wdata;
  logic [ID_W-1:0]     r_hold_dst;
  logic                r_hold_wr;
  logic [15:0]         r_stall_cnt;

  logic                w_w_live;
  logic                w_hit1;
  logic                w_hit2;
  logic                w_hazard;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_alu;
  logic [DATA_W-1:0]   w_dst_val;
  logic                w_accept;
  logic                w_is_mem;
  logic [2:0]          w_shamt;

  assign w_w_live = r_w_valid && r_w_we;
  assign w_hit1   = w_w_live && (src1_id == r_w_dst);
  assign w_hit2   = w_w_live && (src2_id == r_w_dst);

`ifdef DATA_PATH_FWD_EN
  assign w_a      = w_hit1 ? r_w_data : r_rf[src1_id];
  assign w_b      = w_hit2 ? r_w_data : r_rf[src2_id];
  assign w_hazard = 1'b0;
`else
  // Without forwarding, a source matching the pending write waits one cycle
  // so it is read from the register file after the write lands.
  assign w_a      = r_rf[src1_id];
  assign w_b      = r_rf[src2_id];
  assign w_hazard = w_hit1 || w_hit2;
`endif

  assign issue_ready = rst_n && (r_state == S_RUN) && !w_hazard;
  assign w_accept    = issue_valid && issue_ready;
  assign w_is_mem    = (mem_op == 2'd1) || (mem_op == 2'd2);
  assign w_shamt     = imm[2:0];

  always_comb begin
    w_alu = '0;
    case (alu_cmd)
      3'd0:    w_alu = w_a + w_b;
      3'd1:    w_alu = w_a - w_b;
      3'd2:    w_alu = w_a & w_b;
      3'd3:    w_alu = w_a | w_b;
      3'd4:    w_alu = w_a ^ w_b;
      3'd5:    w_alu = w_a << w_shamt;
      3'd6:    w_alu = w_a >> w_shamt;
      default: w_alu = w_b;
    endcase
  end

  always_comb begin
    w_dst_val = w_alu;
    case (dst_sel)
      2'd1:    w_dst_val = imm;
      2'd2:    w_dst_val = dmem_rsp_data;
      default: w_dst_val = w_alu;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) r_rf[i] <= '0;
    end else if (w_w_live) begin
      r_rf[r_w_dst] <= r_w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_w_valid   <= 1'b0;
      r_w_we      <= 1'b0;
      r_w_dst     <= '0;
      r_w_data    <= '0;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_hold_dst  <= '0;
      r_hold_wr   <= 1'b0;
    end else begin
      r_w_valid <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            if (w_is_mem) begin
              r_req_valid <= 1'b1;
              r_req_we    <= (mem_op == 2'd2);
              r_req_addr  <= ADDR_W'(w_a + imm);
              r_req_wdata <= w_b;
              r_hold_dst  <= dst_id;
              r_hold_wr   <= reg_wr_en;
              r_state     <= S_REQ;
            end else begin
              r_w_valid <= 1'b1;
              r_w_we    <= reg_wr_en;
              r_w_dst   <= dst_id;
              r_w_data  <= w_dst_val;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= r_req_we ? S_RUN : S_RSP;
          end
        end
        S_RSP: begin
          if (dmem_rsp_valid) begin
            r_w_valid <= 1'b1;
            r_w_we    <= r_hold_wr;
            r_w_dst   <= r_hold_dst;
            r_w_data  <= dmem_rsp_data;
            r_state   <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && (r_stall_cnt != c_stall_max)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign dmem_req_valid = r_req_valid;
  assign dmem_req_we    = r_req_we;
  assign dmem_req_addr  = r_req_addr;
  assign dmem_req_wdata = r_req_wdata;
  assign dbg_rd_data    = r_rf[dbg_rd_id];
  assign stall_cnt      = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_data_path_pipe.sv
`default_nettype none
// Scoreboard bench for data_path_pipe: stimulus pushes expected writebacks and
// memory requests; a monitor pops and compares them as the DUT presents them.
module tb_data_path_pipe;
  localparam int DATA_W = 8, REG_CNT = 16, ADDR_W = 8, ID_W = 4;
`ifdef DATA_PATH_FWD_EN
  localparam int c_hz = 0;
`else
  localparam int c_hz = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, issue_valid, issue_ready, reg_wr_en;
  logic [ID_W-1:0] dst_id, src1_id, src2_id, dbg_rd_id;
  logic [DATA_W-1:0] imm, dmem_req_wdata, dmem_rsp_data, dbg_rd_data;
  logic [2:0] alu_cmd;
  logic [1:0] dst_sel, mem_op;
  logic dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_rsp_valid;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [15:0] stall_cnt;

  int total = 0, bad = 0;
  logic [ID_W+DATA_W-1:0] w_exp[$];
  logic [ADDR_W+DATA_W:0] m_exp[$];
  logic [ID_W+DATA_W-1:0] w_pop;
  logic [ADDR_W+DATA_W:0] m_pop;
  int st, s0;

  data_path_pipe #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .dst_id(dst_id), .src1_id(src1_id), .src2_id(src2_id), .imm(imm),
    .alu_cmd(alu_cmd), .dst_sel(dst_sel), .reg_wr_en(reg_wr_en), .mem_op(mem_op),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_data(dmem_rsp_data), .dbg_rd_id(dbg_rd_id),
    .dbg_rd_data(dbg_rd_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: writeback results and memory request handshakes
  always @(negedge clk) begin
    if (rst_n && dut.r_w_valid && dut.r_w_we) begin
      if (w_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_unexpected: got dst %0d data 0x%0h expected none", dut.r_w_dst, dut.r_w_data);
      end else begin
        w_pop = w_exp.pop_front();
        check("wb {dst,data}", {20'd0, dut.r_w_dst, dut.r_w_data}, {20'd0, w_pop});
      end
    end
    if (rst_n && dmem_req_valid && dmem_req_ready) begin
      if (m_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL mem_unexpected: got addr 0x%0h expected none", dmem_req_addr);
      end else begin
        m_pop = m_exp.pop_front();
        check("mem {we,addr,wdata}", {15'd0, dmem_req_we, dmem_req_addr, dmem_req_wdata}, {15'd0, m_pop});
      end
    end
  end

  task automatic issue(input logic [3:0] d, s1, s2, input logic [7:0] im,
                       input logic [2:0] cmd, input logic [1:0] sel,
                       input logic we, input logic [1:0] mop, output int stalls);
    bit ok;
    dst_id = d; src1_id = s1; src2_id = s2; imm = im; alu_cmd = cmd;
    dst_sel = sel; reg_wr_en = we; mem_op = mop; issue_valid = 1'b1;
    stalls = 0; ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (issue_ready) ok = 1'b1; else stalls++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL issue_timeout: got ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic alu(input logic [3:0] d, s1, s2, input logic [7:0] im,
                     input logic [2:0] cmd, input logic [1:0] sel,
                     input logic [7:0] exp, output int stalls);
    w_exp.push_back({d, exp});
    issue(d, s1, s2, im, cmd, sel, 1'b1, 2'd0, stalls);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rdreg(input logic [3:0] id, input logic [7:0] exp, input string name);
    dbg_rd_id = id;
    #1;
    check(name, {24'd0, dbg_rd_data}, {24'd0, exp});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tv [6];
    logic [2:0] tc [6];
    logic [7:0] ti [6];
    tc = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    ti = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h3, 8'h0};
    tv = '{8'h45, 8'h00, 8'hBD, 8'hBD, 8'h10, 8'h3C};
    rst_n = 1'b0; issue_valid = 1'b0; dst_id = '0; src1_id = '0; src2_id = '0;
    imm = '0; alu_cmd = '0; dst_sel = '0; reg_wr_en = 1'b0; mem_op = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0; dbg_rd_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", {31'd0, issue_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("stall_cnt_reset", {16'd0, stall_cnt}, 32'd0);
    check("req_valid_reset", {31'd0, dmem_req_valid}, 32'd0);
    check("ready_after_reset", {31'd0, issue_ready}, 32'd1);
    rdreg(4'd1, 8'h00, "r1_reset");

    // r1 = imm 5: old value in W cycle, new value one cycle later
    alu(4'd1, 4'd0, 4'd0, 8'h05, 3'd0, 2'd1, 8'h05, st);
    rdreg(4'd1, 8'h00, "r1_during_wb");
    idle(1);
    rdreg(4'd1, 8'h05, "r1_after_wb");
    alu(4'd2, 4'd0, 4'd0, 8'hFE, 3'd0, 2'd1, 8'hFE, st);
    idle(2);

    // back-to-back dependent ADD/SUB
    s0 = int'(stall_cnt);
    alu(4'd3, 4'd1, 4'd2, 8'h00, 3'd0, 2'd0, 8'h03, st);
    alu(4'd4, 4'd3, 4'd1, 8'h00, 3'd1, 2'd0, 8'hFE, st);
    check("dep_stalls", st, c_hz);
    check("dep_stall_cnt", int'(stall_cnt) - s0, c_hz);
    idle(2);
    rdreg(4'd3, 8'h03, "r3_add");
    rdreg(4'd4, 8'hFE, "r4_sub");

    // store with ready low for 3 cycles while an instruction waits
    s0 = int'(stall_cnt);
    m_exp.push_back({1'b1, 8'h15, 8'hFE});
    issue(4'd0, 4'd1, 4'd2, 8'h10, 3'd0, 2'd0, 1'b0, 2'd2, st);
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_req_valid", {31'd0, dmem_req_valid}, 32'd1);
      check("st_addr_hold", {24'd0, dmem_req_addr}, 32'h15);
      check("st_wdata_hold", {24'd0, dmem_req_wdata}, 32'hFE);
      check("st_ready_low", {31'd0, issue_ready}, 32'd0);
      @(posedge clk); #1;
    end
    issue_valid = 1'b0; dmem_req_ready = 1'b1;
    idle(1);
    dmem_req_ready = 1'b0;
    src1_id = '0; src2_id = '0;
    #1;
    check("st_stall_cnt", int'(stall_cnt) - s0, 3);
    check("st_req_cleared", {31'd0, dmem_req_valid}, 32'd0);
    check("st_back_to_run", {31'd0, issue_ready}, 32'd1);

    // load r5 with response two cycles after handshake, then dependent ADD
    dmem_req_ready = 1'b1;
    m_exp.push_back({1'b0, 8'h20, 8'h00});
    w_exp.push_back({4'd5, 8'hA5});
    issue(4'd5, 4'd0, 4'd0, 8'h20, 3'd0, 2'd2, 1'b1, 2'd1, st);
    idle(1);
    dmem_req_ready = 1'b0;
    check("ld_ready_in_rsp", {31'd0, issue_ready}, 32'd0);
    idle(1);
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 8'hA5;
    idle(1);
    dmem_rsp_valid = 1'b0; dmem_rsp_data = 8'h00;
    alu(4'd6, 4'd5, 4'd5, 8'h00, 3'd0, 2'd0, 8'h4A, st);
    check("ld_dep_stalls", st, c_hz);
    idle(2);
    rdreg(4'd5, 8'hA5, "r5_load");
    rdreg(4'd6, 8'h4A, "r6_add");

    // reset while a load request is pending
    issue(4'd7, 4'd1, 4'd0, 8'h00, 3'd0, 2'd2, 1'b1, 2'd1, st);
    check("rst_req_pending", {31'd0, dmem_req_valid}, 32'd1);
    rst_n = 1'b0;
    idle(1);
    check("rst_req_dropped", {31'd0, dmem_req_valid}, 32'd0);
    check("rst_ready_low", {31'd0, issue_ready}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < REG_CNT; i++) rdreg(4'(i), 8'h00, "rst_regs_zero");
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_state_run", {31'd0, issue_ready}, 32'd1);
    idle(4);
    rdreg(4'd7, 8'h00, "rst_no_held_write");

    // saturate stall counter while stuck in REQ
    alu(4'd1, 4'd0, 4'd0, 8'h81, 3'd0, 2'd1, 8'h81, st);
    idle(2);
    m_exp.push_back({1'b1, 8'h81, 8'h00});
    issue(4'd0, 4'd1, 4'd0, 8'h00, 3'd0, 2'd0, 1'b0, 2'd2, st);
    issue_valid = 1'b1;
    idle(70000);
    check("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    idle(1);
    check("stall_sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    issue_valid = 1'b0; dmem_req_ready = 1'b1;
    idle(1);
    dmem_req_ready = 1'b0;

    // SHL and an ALU op table against r1 = 0x81, r8 = 0x3C
    alu(4'd2, 4'd1, 4'd0, 8'h01, 3'd5, 2'd0, 8'h02, st);
    alu(4'd8, 4'd0, 4'd0, 8'h3C, 3'd0, 2'd1, 8'h3C, st);
    idle(2);
    for (int i = 0; i < 6; i++) alu(4'(9 + i), 4'd1, 4'd8, ti[i], tc[i], 2'd0, tv[i], st);
    idle(2);
    rdreg(4'd2, 8'h02, "r2_shl");
    rdreg(4'd10, 8'h00, "r10_and");
    rdreg(4'd13, 8'h10, "r13_shr");
    check("wb_queue_drained", w_exp.size(), 32'd0);
    check("mem_queue_drained", m_exp.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
